// File: rtl/dds_ctrl_pkg.sv
// Shared types and defaults for the DDS sweep controller.
package dds_ctrl_pkg;

    localparam int unsigned DDS_FWORD_W  = 32;
    localparam int unsigned DDS_STEP_W   = 16;
    localparam int unsigned DDS_SETTLE_W = 32;

    // Frequency word presented to the DDS while no sweep has been loaded
    localparam logic [DDS_FWORD_W-1:0] DDS_RST_FWORD = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        MEAS   = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/dds_settle_timer.sv
// Loadable down-counter; cnt_zero is registered and reflects the count held this cycle.
module dds_settle_timer
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_W = DDS_SETTLE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                en,
    output logic                cnt_zero
);

    logic [SETTLE_W-1:0] cnt;
    logic [SETTLE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt != '0)) begin
            cnt_d = cnt - SETTLE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            cnt_zero <= 1'b1;
        end else begin
            cnt      <= cnt_d;
            cnt_zero <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: writes each DDS frequency word, waits for settling,
// then requests one measurement per point.
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned FWORD_W  = DDS_FWORD_W,
    parameter int unsigned STEP_W   = DDS_STEP_W,
    parameter int unsigned SETTLE_W = DDS_SETTLE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [FWORD_W-1:0]  start_fword,
    input  logic [FWORD_W-1:0]  step_fword,
    input  logic [STEP_W-1:0]   num_steps,
    input  logic [SETTLE_W-1:0] settle_cycles,
    output logic                param_wen,
    output logic [FWORD_W-1:0]  phase_fword,
    output logic                meas_req,
    input  logic                meas_ack,
    output logic [STEP_W-1:0]   step_idx,
    output logic                busy,
    output logic                done
);

    sweep_state_e        state;
    sweep_state_e        state_d;

    // Configuration captured when a sweep is accepted
    logic [FWORD_W-1:0]  step_r;
    logic [STEP_W-1:0]   num_r;
    logic [SETTLE_W-1:0] settle_r;
    logic                cfg_we;

    logic                param_wen_d;
    logic [FWORD_W-1:0]  phase_fword_d;
    logic [STEP_W-1:0]   step_idx_d;
    logic                done_d;

    logic                tmr_load;
    logic                tmr_en;
    logic                tmr_zero;

    dds_settle_timer #(
        .SETTLE_W (SETTLE_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (settle_r),
        .en       (tmr_en),
        .cnt_zero (tmr_zero)
    );

    // phase_fword doubles as the current sweep word; it only moves on a DDS write
    always_comb begin
        state_d       = state;
        cfg_we        = 1'b0;
        param_wen_d   = 1'b0;
        phase_fword_d = phase_fword;
        step_idx_d    = step_idx;
        done_d        = 1'b0;
        tmr_load      = 1'b0;
        tmr_en        = 1'b0;

        if (abort && (state != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (num_steps != '0) begin
                            cfg_we        = 1'b1;
                            state_d       = LOAD;
                            param_wen_d   = 1'b1;
                            phase_fword_d = start_fword;
                            step_idx_d    = '0;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    tmr_load = 1'b1;
                    state_d  = SETTLE;
                end
                SETTLE: begin
                    if (tmr_zero) begin
                        state_d = MEAS;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                MEAS: begin
                    if (meas_ack) begin
                        if (step_idx == (num_r - STEP_W'(1))) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d       = LOAD;
                            param_wen_d   = 1'b1;
                            step_idx_d    = step_idx + STEP_W'(1);
                            phase_fword_d = phase_fword + step_r;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            step_r      <= '0;
            num_r       <= '0;
            settle_r    <= '0;
            param_wen   <= 1'b0;
            phase_fword <= FWORD_W'(DDS_RST_FWORD);
            meas_req    <= 1'b0;
            step_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            if (cfg_we) begin
                step_r   <= step_fword;
                num_r    <= num_steps;
                settle_r <= settle_cycles;
            end
            param_wen   <= param_wen_d;
            phase_fword <= phase_fword_d;
            meas_req    <= (state_d == MEAS);
            step_idx    <= step_idx_d;
            busy        <= (state_d != IDLE);
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl with a cycle-arithmetic reference model.
module tb_dds_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] start_fword;
    logic [31:0] step_fword;
    logic [15:0] num_steps;
    logic [31:0] settle_cycles;
    logic        param_wen;
    logic [31:0] phase_fword;
    logic        meas_req;
    logic        meas_ack;
    logic [15:0] step_idx;
    logic        busy;
    logic        done;

    dds_sweep_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .start_fword   (start_fword),
        .step_fword    (step_fword),
        .num_steps     (num_steps),
        .settle_cycles (settle_cycles),
        .param_wen     (param_wen),
        .phase_fword   (phase_fword),
        .meas_req      (meas_req),
        .meas_ack      (meas_ack),
        .step_idx      (step_idx),
        .busy          (busy),
        .done          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Reference model: outputs derived from cycle numbers and point index.
    // Edge e produces the outputs seen during interval e.
    longint      m_cyc     = 0;
    bit          m_act     = 1'b0;
    int          m_k       = 0;
    int          m_n       = 0;
    longint      m_p       = 0;
    longint      m_sc      = 0;
    logic [31:0] m_start   = '0;
    logic [31:0] m_step    = '0;
    logic [31:0] m_phase   = '0;
    longint      m_done_at = -1;
    logic        e_pw;
    logic        e_meas;

    always @(posedge clk) begin
        bit was_meas;
        m_cyc    = m_cyc + 1;
        was_meas = m_act && ((m_cyc - 1) >= (m_p + 2 + m_sc));
        if (rst) begin
            m_act     = 1'b0;
            m_k       = 0;
            m_phase   = '0;
            m_done_at = -1;
        end else if (abort) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (start) begin
                if (num_steps != 16'd0) begin
                    m_act   = 1'b1;
                    m_k     = 0;
                    m_n     = int'(num_steps);
                    m_sc    = longint'(settle_cycles);
                    m_start = start_fword;
                    m_step  = step_fword;
                    m_p     = m_cyc;
                end else begin
                    m_done_at = m_cyc;
                end
            end
        end else if (was_meas && meas_ack) begin
            if (m_k == m_n - 1) begin
                m_act     = 1'b0;
                m_done_at = m_cyc;
            end else begin
                m_k = m_k + 1;
                m_p = m_cyc;
            end
        end
        e_pw   = m_act && (m_cyc == m_p);
        e_meas = m_act && (m_cyc >= (m_p + 2 + m_sc));
        if (e_pw) m_phase = m_start + m_step * 32'(m_k);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("param_wen",   64'(param_wen),   64'(e_pw));
            check("phase_fword", 64'(phase_fword), 64'(m_phase));
            check("meas_req",    64'(meas_req),    64'(e_meas));
            check("step_idx",    64'(step_idx),    64'(16'(m_k)));
            check("busy",        64'(busy),        64'(m_act));
            check("done",        64'(done),        64'(m_done_at == m_cyc));
        end
    end

    // Ack responder and observation capture
    int          ack_mode = 0;
    int          cap_cyc  = 0;
    int          last_pw  = 0;
    int          meas_rise = 0;
    int          done_cnt = 0;
    logic        meas_prev = 1'b0;
    logic [31:0] pw_q[$];
    int          dly_q[$];
    int          len_q[$];

    always @(negedge clk) begin
        cap_cyc++;
        case (ack_mode)
            0:       meas_ack = 1'b0;
            1:       meas_ack = meas_req && meas_prev;
            2:       meas_ack = 1'b1;
            default: meas_ack = cap_cyc[0];
        endcase
        if (param_wen === 1'b1) begin
            pw_q.push_back(phase_fword);
            last_pw = cap_cyc;
        end
        if (meas_req === 1'b1 && meas_prev === 1'b0) begin
            dly_q.push_back(cap_cyc - last_pw);
            meas_rise = cap_cyc;
        end
        if (meas_req === 1'b0 && meas_prev === 1'b1) len_q.push_back(cap_cyc - meas_rise);
        if (done === 1'b1) done_cnt++;
        meas_prev = (meas_req === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_caps();
        pw_q.delete();
        dly_q.delete();
        len_q.delete();
        done_cnt = 0;
    endtask

    task automatic run_start(input logic [31:0] sf, input logic [31:0] st,
                             input logic [15:0] ns, input logic [31:0] sc);
        start_fword   = sf;
        step_fword    = st;
        num_steps     = ns;
        settle_cycles = sc;
        start         = 1'b1;
        tick(1);
        start         = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check("wait_idle", 64'(busy), 64'd0);
    endtask

    logic [31:0] exp_lin[4];
    int          n_wait;

    initial begin
        exp_lin[0] = 32'h0100_0000;
        exp_lin[1] = 32'h0110_0000;
        exp_lin[2] = 32'h0120_0000;
        exp_lin[3] = 32'h0130_0000;
        rst = 1'b1; start = 1'b0; abort = 1'b0; meas_ack = 1'b0;
        start_fword = '0; step_fword = '0; num_steps = '0; settle_cycles = '0;
        tick(3);
        cmp_en = 1'b1;
        check("rst_param_wen", 64'(param_wen),   64'd0);
        check("rst_phase",     64'(phase_fword), 64'd0);
        check("rst_busy",      64'(busy),        64'd0);
        rst = 1'b0;
        tick(2);

        // Linear 4-point sweep, settle 3, ack one cycle after each request
        clear_caps();
        ack_mode = 1;
        run_start(32'h0100_0000, 32'h0010_0000, 16'd4, 32'd3);
        check("t1_first_wen", 64'(param_wen), 64'd1);
        wait_idle(200);
        tick(3);
        check("t1_wen_count", 64'(pw_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < pw_q.size(); i++) begin
            check("t1_fword", 64'(pw_q[i]), 64'(exp_lin[i]));
            check("t1_req_delay", 64'(dly_q[i]), 64'd5);
        end
        check("t1_done_cnt", 64'(done_cnt), 64'd1);

        // Zero settle, ack tied high
        clear_caps();
        ack_mode = 2;
        run_start(32'h0100_0000, 32'h0010_0000, 16'd4, 32'd0);
        wait_idle(100);
        ack_mode = 0;
        tick(3);
        check("t2_wen_count", 64'(pw_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < dly_q.size() && i < len_q.size(); i++) begin
            check("t2_req_delay", 64'(dly_q[i]), 64'd2);
            check("t2_req_len",   64'(len_q[i]), 64'd1);
        end
        check("t2_done_cnt", 64'(done_cnt), 64'd1);

        // Frequency word wraps modulo 2^32
        clear_caps();
        ack_mode = 1;
        run_start(32'hFFFF_FF00, 32'h0000_0200, 16'd2, 32'd1);
        wait_idle(100);
        tick(2);
        check("t3_wen_count", 64'(pw_q.size()), 64'd2);
        if (pw_q.size() == 2) begin
            check("t3_fword0", 64'(pw_q[0]), 64'h0000_0000_FFFF_FF00);
            check("t3_fword1", 64'(pw_q[1]), 64'h0000_0000_0000_0100);
        end

        // Zero points: done only
        clear_caps();
        ack_mode = 0;
        run_start(32'h0500_0000, 32'h1, 16'd0, 32'd2);
        check("t4_done",      64'(done),      64'd1);
        check("t4_busy",      64'(busy),      64'd0);
        check("t4_param_wen", 64'(param_wen), 64'd0);
        tick(1);
        check("t4_done_clear", 64'(done), 64'd0);
        tick(3);
        check("t4_wen_count", 64'(pw_q.size()), 64'd0);
        check("t4_done_cnt",  64'(done_cnt),    64'd1);

        // Abort in MEAS of point 2, then restart
        clear_caps();
        ack_mode = 1;
        run_start(32'h0200_0000, 32'h0001_0000, 16'd8, 32'd2);
        n_wait = 0;
        while (!(meas_req === 1'b1 && step_idx === 16'd2) && n_wait < 200) begin
            tick(1);
            n_wait++;
        end
        check("t5_reach_meas2", 64'(meas_req), 64'd1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("t5_meas_req", 64'(meas_req), 64'd0);
        check("t5_busy",     64'(busy),     64'd0);
        check("t5_step_idx", 64'(step_idx), 64'd2);
        tick(5);
        check("t5_done_cnt",  64'(done_cnt),    64'd0);
        check("t5_wen_count", 64'(pw_q.size()), 64'd3);
        if (pw_q.size() == 3) check("t5_fword2", 64'(pw_q[2]), 64'h0000_0000_0202_0000);
        run_start(32'h0A00_0000, 32'h0000_0001, 16'd1, 32'd0);
        check("t5_restart_wen",   64'(param_wen),   64'd1);
        check("t5_restart_fword", 64'(phase_fword), 64'h0000_0000_0A00_0000);
        check("t5_restart_idx",   64'(step_idx),    64'd0);
        wait_idle(50);
        tick(2);

        // Reset during SETTLE, with stray start/ack pulses while busy
        clear_caps();
        ack_mode = 3;
        run_start(32'h0300_0000, 32'h0000_0010, 16'd4, 32'd10);
        tick(1);
        start_fword = 32'h1234_5678;
        start       = 1'b1;
        tick(1);
        start       = 1'b0;
        tick(1);
        check("t6_busy_pre",   64'(busy),        64'd1);
        check("t6_wen_count",  64'(pw_q.size()), 64'd1);
        check("t6_meas_pre",   64'(meas_req),    64'd0);
        rst = 1'b1;
        tick(1);
        check("t6_rst_busy",  64'(busy),        64'd0);
        check("t6_rst_phase", 64'(phase_fword), 64'd0);
        check("t6_rst_wen",   64'(param_wen),   64'd0);
        check("t6_rst_idx",   64'(step_idx),    64'd0);
        rst = 1'b0;
        ack_mode = 0;
        tick(4);
        check("t6_no_wen_after", 64'(pw_q.size()), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
